// File: rtl/bcd_pkg.sv
// Shared BCD constants: FSM encoding, digit limit and default sizes used by
// both the BCD-to-binary and binary-to-BCD paths.
package bcd_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] BCD_MAX = 4'd9;

  localparam int unsigned NDIG_DEF  = 5;
  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned ACCW_DEF  = 17;

endpackage

// File: rtl/mul10_add.sv
// One accumulate step: acc*10 + digit using shifts only, plus a non-BCD flag.
module mul10_add
  import bcd_pkg::*;
#(
  parameter int unsigned ACCW = ACCW_DEF
) (
  input  logic [ACCW-1:0] acc,
  input  logic [3:0]      digit,
  output logic [ACCW-1:0] acc_out_c,
  output logic            digit_bad_c
);

  assign acc_out_c   = (acc << 3) + (acc << 1) + ACCW'(digit);
  assign digit_bad_c = (digit > BCD_MAX);

endmodule

// File: rtl/bcd2bin_16.sv
// Sequential packed-BCD to binary converter, one digit per clock, MSD first,
// with start/done handshake, saturation on overflow and invalid-digit flag.
module bcd2bin_16
  import bcd_pkg::*;
#(
  parameter int unsigned NDIG  = NDIG_DEF,
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned ACCW  = ACCW_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [4*NDIG-1:0] bcd_in,
  output logic [WIDTH-1:0]  bin,
  output logic              busy,
  output logic              done,
  output logic              err_digit,
  output logic              err_ovf
);

  localparam int unsigned   IDXW    = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int unsigned   SRW     = 4 * NDIG;
  localparam logic [ACCW-1:0] BIN_MAX = ACCW'({WIDTH{1'b1}});

  logic [1:0]       state_q, state_d;
  logic [SRW-1:0]   sr_q, sr_d;
  logic [ACCW-1:0]  acc_q, acc_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             bad_q, bad_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_digit_q, err_digit_d;
  logic             err_ovf_q, err_ovf_d;

  logic [ACCW-1:0]  mac_acc;
  logic             mac_bad;

  // Shift register presents the current digit at its top nibble
  mul10_add #(.ACCW(ACCW)) u_mul10_add (
    .acc         (acc_q),
    .digit       (sr_q[SRW-1 -: 4]),
    .acc_out_c   (mac_acc),
    .digit_bad_c (mac_bad)
  );

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    bad_d       = bad_q;
    bin_d       = bin_q;
    err_digit_d = err_digit_q;
    err_ovf_d   = err_ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CONV;
          sr_d    = bcd_in;
          acc_d   = '0;
          idx_d   = IDXW'(NDIG - 1);
          bad_d   = 1'b0;
        end
      end
      ST_CONV: begin
        acc_d = mac_acc;
        bad_d = bad_q | mac_bad;
        sr_d  = sr_q << 4;
        idx_d = idx_q - 1'b1;
        if (idx_q == '0) begin
          state_d = ST_DONE;
          idx_d   = '0;
          // Invalid digit dominates overflow
          if (bad_d) begin
            bin_d       = '0;
            err_digit_d = 1'b1;
            err_ovf_d   = 1'b0;
          end else if (mac_acc > BIN_MAX) begin
            bin_d       = '1;
            err_digit_d = 1'b0;
            err_ovf_d   = 1'b1;
          end else begin
            bin_d       = mac_acc[WIDTH-1:0];
            err_digit_d = 1'b0;
            err_ovf_d   = 1'b0;
          end
        end
      end
      ST_DONE: begin
        if (start) begin
          state_d = ST_CONV;
          sr_d    = bcd_in;
          acc_d   = '0;
          idx_d   = IDXW'(NDIG - 1);
          bad_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_CONV);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sr_q        <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      bad_q       <= 1'b0;
      bin_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_digit_q <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      bad_q       <= bad_d;
      bin_q       <= bin_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_digit_q <= err_digit_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  assign bin       = bin_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err_digit = err_digit_q;
  assign err_ovf   = err_ovf_q;

endmodule

// File: tb/tb_bcd2bin_16.sv
// Scoreboard bench for bcd2bin_16: directed boundary/handshake/reset cases
// followed by randomized back-to-back conversions against a decimal model.
module tb_bcd2bin_16;

  typedef struct packed {
    logic [15:0] bin;
    logic        ed;
    logic        eo;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        start;
  logic [19:0] bcd_in;
  logic [15:0] bin;
  logic        busy;
  logic        done;
  logic        err_digit;
  logic        err_ovf;

  int   checks;
  int   errors;
  exp_t exp_q[$];

  bcd2bin_16 dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .bcd_in    (bcd_in),
    .bin       (bin),
    .busy      (busy),
    .done      (done),
    .err_digit (err_digit),
    .err_ovf   (err_ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Decimal reference: weigh each nibble by its power of ten
  function automatic exp_t ref_model(input logic [19:0] b);
    exp_t        e;
    int unsigned v;
    int unsigned w;
    logic        bad;
    v = 0; w = 1; bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (b[4*i +: 4] > 4'd9) bad = 1'b1;
      v = v + w * int'(b[4*i +: 4]);
      w = w * 10;
    end
    if (bad)            e = '{bin: 16'h0000, ed: 1'b1, eo: 1'b0};
    else if (v > 65535) e = '{bin: 16'hFFFF, ed: 1'b0, eo: 1'b1};
    else                e = '{bin: v[15:0],  ed: 1'b0, eo: 1'b0};
    return e;
  endfunction

  function automatic logic [19:0] to_bcd(input int unsigned v);
    logic [19:0] b;
    int unsigned t;
    t = v;
    for (int i = 0; i < 5; i++) begin
      b[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return b;
  endfunction

  // Monitor: every done pulse consumes one expected result
  always @(negedge clock) begin
    if (done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: bin=%h ed=%b eo=%b but nothing was expected", bin, err_digit, err_ovf);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bin !== e.bin || err_digit !== e.ed || err_ovf !== e.eo) begin
          errors++;
          $display("FAIL result: got bin=%h ed=%b eo=%b, expected bin=%h ed=%b eo=%b",
                   bin, err_digit, err_ovf, e.bin, e.ed, e.eo);
        end
      end
    end
  end

  // Issue a conversion at the current negedge; returns at the negedge showing done.
  task automatic run(input logic [19:0] b, input bit extra_start, input bit scramble);
    int  busy_cnt;
    int  lat;
    bit  seen;
    busy_cnt = 0; lat = 0; seen = 1'b0;
    bcd_in = b;
    start  = 1'b1;
    exp_q.push_back(ref_model(b));
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clock);
      if (k == 1) begin
        start = 1'b0;
        if (scramble) bcd_in = 20'($urandom);
      end
      if (extra_start && k == 2) begin
        bcd_in = 20'h99999;
        start  = 1'b1;
      end
      if (extra_start && k == 3) start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    checks++;
    if (!seen || lat != 6) begin
      errors++;
      $display("FAIL latency: bcd=%h done after %0d cycles (seen=%0b), required 6", b, lat, seen);
    end
    checks++;
    if (busy_cnt != 5) begin
      errors++;
      $display("FAIL busy_len: bcd=%h busy for %0d cycles, required 5", b, busy_cnt);
    end
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  initial begin
    logic [19:0] dir [0:6];
    checks = 0; errors = 0;
    reset = 1'b1; start = 1'b0; bcd_in = '0;
    repeat (3) @(negedge clock);
    checks++;
    if ({bin, busy, done, err_digit, err_ovf} !== 20'h0) begin
      errors++;
      $display("FAIL reset_state: bin=%h busy=%b done=%b ed=%b eo=%b, required all 0",
               bin, busy, done, err_digit, err_ovf);
    end
    reset = 1'b0;
    idle(2);

    dir[0] = 20'h00000; dir[1] = 20'h65535; dir[2] = 20'h65536; dir[3] = 20'h99999;
    dir[4] = 20'h12A45; dir[5] = 20'h7FFFF; dir[6] = 20'h00001;
    for (int i = 0; i < 7; i++) begin
      run(dir[i], 1'b0, 1'b0);
      idle(2);
    end

    // Start pulse while busy is ignored
    run(20'h01234, 1'b1, 1'b0);
    // Start in the DONE cycle: back-to-back
    run(20'h00042, 1'b0, 1'b0);
    idle(10);
    // Input changes after the start edge are ignored
    run(20'h31415, 1'b0, 1'b1);
    idle(2);

    // Reset in the third CONV cycle: no done, outputs cleared
    bcd_in = 20'h00777;
    start  = 1'b1;
    @(negedge clock); start = 1'b0;
    @(negedge clock);
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    checks++;
    if ({bin, busy, done, err_digit, err_ovf} !== 20'h0) begin
      errors++;
      $display("FAIL reset_midconv: bin=%h busy=%b done=%b ed=%b eo=%b, required all 0",
               bin, busy, done, err_digit, err_ovf);
    end
    idle(10);
    run(20'h00500, 1'b0, 1'b0);
    idle(2);

    // Randomized back-to-back conversions, mostly valid BCD
    for (int n = 0; n < 1500; n++) begin
      logic [19:0] b;
      if ($urandom_range(0, 7) == 0) b = 20'($urandom);
      else if ($urandom_range(0, 3) == 0) b = to_bcd($urandom_range(60000, 70000));
      else b = to_bcd($urandom_range(0, 99999));
      run(b, 1'b0, 1'b0);
      if ($urandom_range(0, 9) == 0) idle($urandom_range(1, 3));
    end
    idle(10);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results never produced, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
